// File: rtl/core_pkg.sv
// Shared core definitions used by the pipeline hazard/stall controller.
package core_pkg;

    // Hazard controller operating states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_e;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Per pipeline-register control pair.
    typedef struct packed {
        logic write;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, taken-branch
// flushes, data-memory freeze and a sticky memory-timeout halt.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs1,
    input  logic             IF_ID_uses_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int               WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);

    hazard_state_e     state_r;
    hazard_state_e     state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              halt_r;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic [CNT_W-1:0]  flush_count_r;

    logic        load_use_s;
    logic        mem_wait_s;
    logic        freeze_s;
    logic        flush_s;
    logic        bubble_s;
    logic        stall_inc_s;
    stage_ctrl_t pc_ctrl_s;
    stage_ctrl_t if_id_ctrl_s;
    stage_ctrl_t id_ex_ctrl_s;
    stage_ctrl_t ex_mem_ctrl_s;
    stage_ctrl_t mem_wb_ctrl_s;

    // Hazard detection, next-state selection and prioritised stage controls.
    always_comb begin
        state_nxt_s   = state_r;
        pc_ctrl_s     = '{write: 1'b0, flush: 1'b0};
        if_id_ctrl_s  = '{write: 1'b0, flush: 1'b0};
        id_ex_ctrl_s  = '{write: 1'b0, flush: 1'b0};
        ex_mem_ctrl_s = '{write: 1'b0, flush: 1'b0};
        mem_wb_ctrl_s = '{write: 1'b0, flush: 1'b0};

        load_use_s = ID_EX_MemRead && (ID_EX_rd != REG_ZERO) &&
                     ((IF_ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                      (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
        mem_wait_s = dmem_req && !dmem_ready;

        case (state_r)
            RUN: begin
                if (mem_wait_s) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_wait_s) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            HALT: begin
                state_nxt_s = HALT;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase

        // A pending branch is held off by a freeze; EX keeps it for later.
        freeze_s    = (state_r == HALT) || mem_wait_s;
        flush_s     = !freeze_s && branch_taken;
        bubble_s    = !freeze_s && !branch_taken && load_use_s;
        stall_inc_s = (state_r != HALT) && (freeze_s || bubble_s);

        if (!rst_n || freeze_s) begin
            pc_ctrl_s     = '{write: 1'b0, flush: 1'b0};
            if_id_ctrl_s  = '{write: 1'b0, flush: 1'b0};
            id_ex_ctrl_s  = '{write: 1'b0, flush: 1'b0};
            ex_mem_ctrl_s = '{write: 1'b0, flush: 1'b0};
            mem_wb_ctrl_s = '{write: 1'b0, flush: 1'b0};
        end else if (flush_s) begin
            pc_ctrl_s     = '{write: 1'b1, flush: 1'b0};
            if_id_ctrl_s  = '{write: 1'b1, flush: 1'b1};
            id_ex_ctrl_s  = '{write: 1'b1, flush: 1'b1};
            ex_mem_ctrl_s = '{write: 1'b1, flush: 1'b0};
            mem_wb_ctrl_s = '{write: 1'b1, flush: 1'b0};
        end else if (bubble_s) begin
            pc_ctrl_s     = '{write: 1'b0, flush: 1'b0};
            if_id_ctrl_s  = '{write: 1'b0, flush: 1'b0};
            id_ex_ctrl_s  = '{write: 1'b1, flush: 1'b1};
            ex_mem_ctrl_s = '{write: 1'b1, flush: 1'b0};
            mem_wb_ctrl_s = '{write: 1'b1, flush: 1'b0};
        end else begin
            pc_ctrl_s     = '{write: 1'b1, flush: 1'b0};
            if_id_ctrl_s  = '{write: 1'b1, flush: 1'b0};
            id_ex_ctrl_s  = '{write: 1'b1, flush: 1'b0};
            ex_mem_ctrl_s = '{write: 1'b1, flush: 1'b0};
            mem_wb_ctrl_s = '{write: 1'b1, flush: 1'b0};
        end
    end

    // State, wait timer, sticky halt and saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= RUN;
            wait_cnt_r     <= '0;
            halt_r         <= 1'b0;
            stall_cycles_r <= '0;
            flush_count_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            halt_r  <= (state_nxt_s == HALT);
            if ((state_r != MEM_WAIT) && (state_nxt_s == MEM_WAIT)) begin
                wait_cnt_r <= '0;
            end else if (state_r == MEM_WAIT) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (stall_inc_s && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_s && (flush_count_r != CNT_MAX)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign pc_write     = pc_ctrl_s.write;
    assign if_id_write  = if_id_ctrl_s.write;
    assign if_id_flush  = if_id_ctrl_s.flush;
    assign id_ex_flush  = id_ex_ctrl_s.flush;
    assign ex_mem_write = ex_mem_ctrl_s.write;
    assign mem_wb_write = mem_wb_ctrl_s.write;
    assign halt         = halt_r;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write}
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_FLUSH  = 6'b111111;
    localparam logic [5:0] C_BUBBLE = 6'b000111;
    localparam logic [5:0] C_NORMAL = 6'b110011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic             IF_ID_uses_rs1, IF_ID_uses_rs2, ID_EX_MemRead;
    logic             branch_taken, dmem_req, dmem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic             ex_mem_write, mem_wb_write, halt;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [5:0]       ctrl_s;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: consecutive memory-wait streak, halt flag, counters.
    int m_streak;
    bit m_halted;
    int m_stall;
    int m_flush;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [0:11];

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .halt(halt), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctrl_s = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write};

    // Free-running core clock.
    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_load_use();
        return ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
               ((IF_ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
    endfunction

    function automatic logic [5:0] model_ctrl();
        bit mw;
        mw = dmem_req && !dmem_ready;
        if (!rst_n || m_halted || mw) return C_FREEZE;
        if (branch_taken)             return C_FLUSH;
        if (model_load_use())         return C_BUBBLE;
        return C_NORMAL;
    endfunction

    task automatic model_reset();
        m_streak = 0;
        m_halted = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic model_clock();
        bit mw;
        mw = dmem_req && !dmem_ready;
        if (!m_halted) begin
            if (mw || (model_load_use() && !branch_taken)) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
            if (!mw && branch_taken) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
            // First waiting cycle is spent in RUN, then MEM_TIMEOUT cycles in MEM_WAIT.
            if (mw) begin
                m_streak++;
                if (m_streak == MEM_TIMEOUT + 1) m_halted = 1'b1;
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic mr, input logic [4:0] rd, input logic br, input logic req,
                         input logic rdy);
        IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; IF_ID_uses_rs1 = u1; IF_ID_uses_rs2 = u2;
        ID_EX_MemRead = mr; ID_EX_rd = rd; branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock cycle: check combinational controls mid-cycle, then registered state after the edge.
    task automatic step(input logic [5:0] exp_ctrl, input string tag);
        #1;
        check_vec({tag, "_ctrl"}, ctrl_s, exp_ctrl);
        check_int({tag, "_halt_pre"}, int'(halt), int'(m_halted));
        model_clock();
        @(posedge clk);
        #1;
        check_int({tag, "_stall"}, int'(stall_cycles), m_stall);
        check_int({tag, "_flush"}, int'(flush_count), m_flush);
        check_int({tag, "_halt"}, int'(halt), int'(m_halted));
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst_n = 1'b0;
        #2;
        check_vec({tag, "_rst_ctrl"}, ctrl_s, C_FREEZE);
        check_int({tag, "_rst_halt"}, int'(halt), 0);
        check_int({tag, "_rst_stall"}, int'(stall_cycles), 0);
        check_int({tag, "_rst_flush"}, int'(flush_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_BUBBLE}; // load-use via rs1
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORMAL}; // bubble cleared MemRead
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORMAL}; // rd = x0
        vecs[3]  = '{5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_BUBBLE}; // load-use via rs2
        vecs[4]  = '{5'd1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORMAL}; // rs2 not read
        vecs[5]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORMAL}; // not a load
        vecs[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH};  // branch beats load-use
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH};  // branch alone
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORMAL}; // ready memory access
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE}; // freeze beats branch
        vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_FLUSH};  // released, branch now
        vecs[11] = '{5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NORMAL}; // load, no match

        idle();
        rst_n = 1'b0;
        #2;
        do_reset("init");

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].mr,
                  vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
            step(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Branch together with load-use: flush only.
        do_reset("brlu");
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step(C_FLUSH, "brlu");
        check_int("brlu_flush_count", int'(flush_count), 1);
        check_int("brlu_stall_cycles", int'(stall_cycles), 0);

        // Three frozen cycles, then release; state must be back in RUN.
        do_reset("wait3");
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            step(C_FREEZE, "wait3_frz");
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(C_NORMAL, "wait3_rel");
        check_int("wait3_stall_cycles", int'(stall_cycles), 3);
        idle();
        step(C_NORMAL, "wait3_run");

        // Timeout: never ready; halt is sticky and freezes everything.
        do_reset("tmo");
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            step(C_FREEZE, "tmo_wait");
        end
        check_int("tmo_halt", int'(halt), 1);
        for (int i = 0; i < 3; i++) begin
            drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
            step(C_FREEZE, "tmo_held");
        end
        check_int("tmo_stall_frozen", int'(stall_cycles), MEM_TIMEOUT + 1);
        check_int("tmo_halt_sticky", int'(halt), 1);

        // Reset asserted mid-wait aborts immediately.
        do_reset("midrst");
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            step(C_FREEZE, "midrst_wait");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("midrst_ctrl", ctrl_s, C_FREEZE);
        check_int("midrst_stall", int'(stall_cycles), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        step(C_NORMAL, "midrst_norm");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(C_FREEZE, "midrst_frz");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(C_NORMAL, "midrst_rel");

        // Counter saturation with back-to-back bubbles.
        do_reset("sat");
        drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            step(C_BUBBLE, "sat");
        end
        check_int("sat_stall_max", int'(stall_cycles), CNT_MAX);

        // Randomized run against the behavioural model.
        do_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rnd");
            end
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) != 0));
            step(model_ctrl(), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
